// File: rtl/cube_pkg.sv
// Shared constants for the cube net renderer: face indices, sticker codes,
// net placement tables, FSM encoding and the RGB333 palette.
package cube_pkg;

    localparam int FRONT  = 0;
    localparam int BACK   = 1;
    localparam int LEFT   = 2;
    localparam int RIGHT  = 3;
    localparam int TOP    = 4;
    localparam int BOTTOM = 5;

    localparam logic [2:0] CODE_WHITE  = 3'd0;
    localparam logic [2:0] CODE_YELLOW = 3'd1;
    localparam logic [2:0] CODE_RED    = 3'd2;
    localparam logic [2:0] CODE_ORANGE = 3'd3;
    localparam logic [2:0] CODE_GREEN  = 3'd4;
    localparam logic [2:0] CODE_BLUE   = 3'd5;

    localparam logic [8:0] COLOUR_BORDER = 9'h000;

    // Net position of each face in face units; entries 6 and 7 are never selected.
    localparam logic [1:0] FACE_FX [0:7] = '{FRONT: 2'd1, BACK: 2'd3, LEFT: 2'd0,
                                             RIGHT: 2'd2, TOP: 2'd1, BOTTOM: 2'd1,
                                             default: 2'd0};
    localparam logic [1:0] FACE_FY [0:7] = '{FRONT: 2'd1, BACK: 2'd1, LEFT: 2'd1,
                                             RIGHT: 2'd1, TOP: 2'd0, BOTTOM: 2'd2,
                                             default: 2'd0};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_DRAW  = 3'd3,
        ST_NEXT  = 3'd4,
        ST_FIN   = 3'd5
    } state_t;

    function automatic logic [8:0] code_to_rgb333(input logic [2:0] code);
        case (code)
            CODE_WHITE:  code_to_rgb333 = 9'h1FF;
            CODE_YELLOW: code_to_rgb333 = 9'h1F8;
            CODE_RED:    code_to_rgb333 = 9'h1C0;
            CODE_ORANGE: code_to_rgb333 = 9'h1E0;
            CODE_GREEN:  code_to_rgb333 = 9'h038;
            CODE_BLUE:   code_to_rgb333 = 9'h007;
            default:     code_to_rgb333 = 9'h000;
        endcase
    endfunction

endpackage

// File: rtl/sticker_painter.sv
// Walks one CELLxCELL sticker cell, emitting one registered pixel per cycle
// while go is high; the last column and row of the cell form the black border.
module sticker_painter
    import cube_pkg::*;
#(
    parameter int CELL = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       go,
    input  logic [7:0] base_x,
    input  logic [7:0] base_y,
    input  logic [2:0] code,
    output logic       last,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [8:0] colour,
    output logic       plot
);

    localparam logic [7:0] CELL_M1 = 8'(CELL - 1);

    logic [7:0] px_q, px_d, py_q, py_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [8:0] colour_q, colour_d;
    logic       plot_q, plot_d;

    assign last = (px_q == CELL_M1) && (py_q == CELL_M1);

    // Counters rest at zero between stickers so each cell starts at its corner.
    always_comb begin
        px_d     = 8'd0;
        py_d     = 8'd0;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        if (go) begin
            x_d    = base_x + px_q;
            y_d    = 7'(base_y + py_q);
            plot_d = 1'b1;
            if ((px_q == CELL_M1) || (py_q == CELL_M1)) begin
                colour_d = COLOUR_BORDER;
            end else begin
                colour_d = code_to_rgb333(code);
            end
            if (last) begin
                px_d = 8'd0;
                py_d = 8'd0;
            end else if (px_q == CELL_M1) begin
                px_d = 8'd0;
                py_d = py_q + 8'd1;
            end else begin
                px_d = px_q + 8'd1;
                py_d = py_q;
            end
        end else begin
            plot_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            px_q     <= 8'd0;
            py_q     <= 8'd0;
            x_q      <= 8'd0;
            y_q      <= 7'd0;
            colour_q <= 9'h000;
            plot_q   <= 1'b0;
        end else begin
            px_q     <= px_d;
            py_q     <= py_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;

endmodule

// File: rtl/cube_net_drawer.sv
// Renders an NxNxN cube state as a cross-shaped net into the VGA frame buffer.
// Define CUBE_NET_DIFF_EN to redraw only stickers that changed since the last pass.
module cube_net_drawer
    import cube_pkg::*;
#(
    parameter int GRID = 3,
    parameter int CELL = 8,
    parameter int X0   = 32,
    parameter int Y0   = 24
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [6*GRID*GRID*3-1:0]  cube_state,
    input  logic                      start,
    output logic [7:0]                x,
    output logic [6:0]                y,
    output logic [8:0]                colour,
    output logic                      plot,
    output logic                      busy,
    output logic                      done
);

    localparam int NSTK  = 6 * GRID * GRID;
    localparam int SW    = NSTK * 3;
    localparam int IDX_W = $clog2(NSTK);
    localparam int F     = GRID * CELL;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSTK - 1);
    localparam logic [2:0]       G_M1     = 3'(GRID - 1);

    state_t            state_q, state_d;
    logic [SW-1:0]     snap_q;
    logic              force_pend_q;
    logic [IDX_W-1:0]  idx_q;
    logic [2:0]        face_q, row_q, col_q;
    logic              busy_q, busy_d, done_q, done_d;
    logic [2:0]        code_s;
    logic              draw_s, paint_go_s, paint_last_s;
    logic [7:0]        base_x_s, base_y_s;

    assign code_s   = snap_q[3*int'(idx_q) +: 3];
    assign base_x_s = 8'(X0) + 8'(FACE_FX[face_q]) * 8'(F) + 8'(col_q) * 8'(CELL);
    assign base_y_s = 8'(Y0) + 8'(FACE_FY[face_q]) * 8'(F) + 8'(row_q) * 8'(CELL);

`ifdef CUBE_NET_DIFF_EN
    logic [SW-1:0] shadow_q;
    logic          force_pass_q;

    assign draw_s = force_pass_q || (shadow_q[3*int'(idx_q) +: 3] != code_s);

    // Shadow tracks what is on screen; a forced pass refreshes every entry.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            shadow_q     <= '0;
            force_pass_q <= 1'b0;
        end else begin
            if (state_q == ST_LOAD) begin
                force_pass_q <= force_pend_q;
            end
            if ((state_q == ST_CHECK) && draw_s) begin
                shadow_q[3*int'(idx_q) +: 3] <= code_s;
            end
        end
    end
`else
    assign draw_s = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            snap_q       <= '0;
            force_pend_q <= 1'b1;
            idx_q        <= '0;
            face_q       <= 3'd0;
            row_q        <= 3'd0;
            col_q        <= 3'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            // A start coinciding with LOAD must survive to request the next pass.
            force_pend_q <= start || (force_pend_q && (state_q != ST_LOAD));
            if (state_q == ST_LOAD) begin
                snap_q <= cube_state;
                idx_q  <= '0;
                face_q <= 3'd0;
                row_q  <= 3'd0;
                col_q  <= 3'd0;
            end else if (state_q == ST_NEXT) begin
                idx_q <= idx_q + IDX_W'(1);
                if (col_q == G_M1) begin
                    col_q <= 3'd0;
                    if (row_q == G_M1) begin
                        row_q  <= 3'd0;
                        face_q <= face_q + 3'd1;
                    end else begin
                        row_q <= row_q + 3'd1;
                    end
                end else begin
                    col_q <= col_q + 3'd1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (force_pend_q || (cube_state != snap_q)) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD:  state_d = ST_CHECK;
            ST_CHECK: state_d = draw_s ? ST_DRAW : ST_NEXT;
            ST_DRAW:  state_d = paint_last_s ? ST_NEXT : ST_DRAW;
            ST_NEXT:  state_d = (idx_q == LAST_IDX) ? ST_FIN : ST_CHECK;
            ST_FIN:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // busy/done are registered from the next state so they line up with it.
    always_comb begin
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_FIN);
        paint_go_s = (state_q == ST_DRAW);
    end

    sticker_painter #(
        .CELL (CELL)
    ) u_painter (
        .clk    (clk),
        .resetn (resetn),
        .go     (paint_go_s),
        .base_x (base_x_s),
        .base_y (base_y_s),
        .code   (code_s),
        .last   (paint_last_s),
        .x      (x),
        .y      (y),
        .colour (colour),
        .plot   (plot)
    );

    assign busy = busy_q;
    assign done = done_q;

endmodule
